// File: rtl/alu_issue_unit_pkg.sv
// rtl/alu_issue_unit_pkg.sv - shared constants, instruction fields and FSM encoding for the ALU issue unit
package alu_issue_unit_pkg;

  localparam logic [2:0] FUN_NOP = 3'd0;
  localparam logic [2:0] FUN_ADD = 3'd1;
  localparam logic [2:0] FUN_SUB = 3'd2;
  localparam logic [2:0] FUN_NOR = 3'd3;
  localparam logic [2:0] FUN_AND = 3'd4;
  localparam logic [2:0] FUN_OR  = 3'd5;
  localparam logic [2:0] FUN_XOR = 3'd6;

  localparam int INSTR_W = 16;
  localparam int FUN_MSB = 15;
  localparam int FUN_LSB = 13;
  localparam int RD_MSB  = 12;
  localparam int RD_LSB  = 10;
  localparam int RA_MSB  = 9;
  localparam int RA_LSB  = 7;
  localparam int RB_MSB  = 6;
  localparam int RB_LSB  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_issue_unit_regfile.sv
// rtl/alu_issue_unit_regfile.sv - register file with prioritised dual write and three combinational reads
module alu_regfile #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              host_we,
  input  logic [REG_AW-1:0] host_waddr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic [REG_AW-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [REG_AW-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b,
  input  logic [REG_AW-1:0] dbg_raddr,
  output logic [DATA_W-1:0] dbg_rdata
);

  localparam int DEPTH = 1 << REG_AW;

  logic [DATA_W-1:0] regs [DEPTH];

  // Writeback beats the host when both target the same register on one edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wb_we && wb_addr == REG_AW'(i))
          regs[i] <= wb_data;
        else if (host_we && host_waddr == REG_AW'(i))
          regs[i] <= host_wdata;
      end
    end
  end

  assign rdata_a   = regs[raddr_a];
  assign rdata_b   = regs[raddr_b];
  assign dbg_rdata = regs[dbg_raddr];

endmodule

// File: rtl/alu_issue_unit.sv
// rtl/alu_issue_unit.sv - three-cycle issue/execute/writeback sequencer around an external ALU
module alu_issue_unit
  import alu_issue_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 3,
  parameter int CNT_W  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [15:0]        instr,
  input  logic               host_we,
  input  logic [REG_AW-1:0]  host_waddr,
  input  logic [DATA_W-1:0]  host_wdata,
  input  logic [REG_AW-1:0]  dbg_raddr,
  output logic [DATA_W-1:0]  dbg_rdata,
  output logic [DATA_W-1:0]  alu_opera,
  output logic [DATA_W-1:0]  alu_operb,
  output logic [2:0]         alu_fun,
  input  logic [DATA_W-1:0]  alu_result,
  input  logic               alu_carry,
  input  logic               alu_zero,
  input  logic               alu_negative,
  output logic               flag_c,
  output logic               flag_z,
  output logic               flag_n,
  output logic               done,
  output logic [CNT_W-1:0]   op_count
);

  state_t            state, state_nx;
  logic              accept, in_exec;
  logic [2:0]        fun_q;
  logic [REG_AW-1:0] rd_q, ra_q, rb_q;
  logic [DATA_W-1:0] rdata_a, rdata_b, opera_q, operb_q;
  logic              unused_instr_bits;

  assign unused_instr_bits = ^instr[RB_LSB-1:0];
  assign accept = instr_valid && instr_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = EXEC;
      EXEC:    state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    instr_ready = 1'b0;
    in_exec     = 1'b0;
    done        = 1'b0;
    case (state)
      IDLE:    instr_ready = 1'b1;
      EXEC:    in_exec     = 1'b1;
      DONE:    done        = 1'b1;
      default: instr_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fun_q <= '0;
      rd_q  <= '0;
      ra_q  <= '0;
      rb_q  <= '0;
    end else if (accept) begin
      fun_q <= instr[FUN_MSB:FUN_LSB];
      rd_q  <= instr[RD_MSB:RD_LSB];
      ra_q  <= instr[RA_MSB:RA_LSB];
      rb_q  <= instr[RB_MSB:RB_LSB];
    end
  end

  // Operands are captured at the end of EXEC so they hold steady while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opera_q  <= '0;
      operb_q  <= '0;
      flag_c   <= 1'b0;
      flag_z   <= 1'b0;
      flag_n   <= 1'b0;
      op_count <= '0;
    end else if (in_exec) begin
      opera_q  <= rdata_a;
      operb_q  <= rdata_b;
      flag_c   <= alu_carry;
      flag_z   <= alu_zero;
      flag_n   <= alu_negative;
      op_count <= op_count + 1'b1;
    end
  end

  assign alu_opera = in_exec ? rdata_a : opera_q;
  assign alu_operb = in_exec ? rdata_b : operb_q;
  assign alu_fun   = in_exec ? fun_q   : FUN_NOP;

  alu_regfile #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_regfile (
    .clk        (clk),
    .rst_n      (rst_n),
    .wb_we      (in_exec),
    .wb_addr    (rd_q),
    .wb_data    (alu_result),
    .host_we    (host_we),
    .host_waddr (host_waddr),
    .host_wdata (host_wdata),
    .raddr_a    (ra_q),
    .rdata_a    (rdata_a),
    .raddr_b    (rb_q),
    .rdata_b    (rdata_b),
    .dbg_raddr  (dbg_raddr),
    .dbg_rdata  (dbg_rdata)
  );

endmodule

// File: tb/tb_alu_issue_unit.sv
// tb/tb_alu_issue_unit.sv - scoreboard bench for alu_issue_unit with a behavioural ALU and register model
module tb_alu_issue_unit;
  import alu_issue_unit_pkg::*;

  localparam int DATA_W = 32;
  localparam int REG_AW = 3;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              instr_valid;
  logic              instr_ready;
  logic [15:0]       instr;
  logic              host_we;
  logic [REG_AW-1:0] host_waddr;
  logic [DATA_W-1:0] host_wdata;
  logic [REG_AW-1:0] dbg_raddr;
  logic [DATA_W-1:0] dbg_rdata;
  logic [DATA_W-1:0] alu_opera, alu_operb, alu_result;
  logic [2:0]        alu_fun;
  logic              alu_carry, alu_zero, alu_negative;
  logic              flag_c, flag_z, flag_n, done;
  logic [CNT_W-1:0]  op_count;

  always #5 clk = ~clk;

  alu_issue_unit #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .host_we(host_we), .host_waddr(host_waddr), .host_wdata(host_wdata),
    .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata), .alu_opera(alu_opera),
    .alu_operb(alu_operb), .alu_fun(alu_fun), .alu_result(alu_result),
    .alu_carry(alu_carry), .alu_zero(alu_zero), .alu_negative(alu_negative),
    .flag_c(flag_c), .flag_z(flag_z), .flag_n(flag_n), .done(done), .op_count(op_count)
  );

  typedef struct packed {
    logic [31:0] r;
    logic        c;
    logic        z;
    logic        n;
  } alu_out_t;

  // 33-bit arithmetic: bit 32 is carry/borrow, zero looks at all 33 bits
  function automatic alu_out_t alu_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] w;
    case (f)
      3'd1:    w = {1'b0, a} + {1'b0, b};
      3'd2:    w = {1'b0, a} - {1'b0, b};
      3'd3:    w = {1'b0, ~(a | b)};
      3'd4:    w = {1'b0, a & b};
      3'd5:    w = {1'b0, a | b};
      3'd6:    w = {1'b0, a ^ b};
      default: w = 33'd0;
    endcase
    alu_model.r = w[31:0];
    alu_model.c = w[32];
    alu_model.z = (w == 33'd0);
    alu_model.n = w[31];
  endfunction

  alu_out_t alu_now;
  assign alu_now      = alu_model(alu_fun, alu_opera, alu_operb);
  assign alu_result   = alu_now.r;
  assign alu_carry    = alu_now.c;
  assign alu_zero     = alu_now.z;
  assign alu_negative = alu_now.n;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  fun;
    int          acc;
  } exec_exp_t;

  typedef struct {
    logic [2:0]  rd;
    logic [31:0] r;
    logic        c, z, n;
    logic [15:0] cnt;
    logic [31:0] a;
    int          acc;
  } done_exp_t;

  exec_exp_t   eq[$];
  done_exp_t   dq[$];
  logic [31:0] mregs [8];
  logic [15:0] mcnt;
  logic        mc, mz, mn;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          done_seen = 0;
  int          n_issued = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mregs[i] = '0;
    mcnt = '0; mc = 0; mz = 0; mn = 0;
  endtask

  task automatic host_write(input logic [2:0] addr, input logic [31:0] data);
    @(negedge clk);
    host_we = 1'b1; host_waddr = addr; host_wdata = data;
    @(posedge clk); #1;
    host_we = 1'b0;
    mregs[addr] = data;
  endtask

  task automatic issue(input logic [2:0] f, input logic [2:0] rd, input logic [2:0] ra,
                       input logic [2:0] rb, input bit keep_valid, input bit hw_en,
                       input logic [2:0] hw_addr, input logic [31:0] hw_data, output int acc);
    int        guard;
    alu_out_t  o;
    exec_exp_t ee;
    done_exp_t de;
    guard = 0;
    acc = -1;
    @(negedge clk);
    instr = {f, rd, ra, rb, 4'($urandom)};
    instr_valid = 1'b1;
    while (!instr_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!instr_ready) begin
      check("accept_timeout", {31'd0, instr_ready}, 32'd1);
      instr_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    acc = cyc;
    if (!keep_valid) instr_valid = 1'b0;
    o = alu_model(f, mregs[ra], mregs[rb]);
    mcnt = mcnt + 16'd1;
    ee.a = mregs[ra]; ee.b = mregs[rb]; ee.fun = f; ee.acc = acc;
    eq.push_back(ee);
    de.rd = rd; de.r = o.r; de.c = o.c; de.z = o.z; de.n = o.n;
    de.cnt = mcnt; de.a = mregs[ra]; de.acc = acc;
    dq.push_back(de);
    n_issued++;
    if (hw_en) begin
      host_we = 1'b1; host_waddr = hw_addr; host_wdata = hw_data;
    end
    @(posedge clk); #1;
    host_we = 1'b0;
    if (hw_en) mregs[hw_addr] = hw_data;
    mregs[rd] = o.r;
    mc = o.c; mz = o.z; mn = o.n;
  endtask

  // Monitor: compares EXEC-cycle ALU drive and DONE-cycle writeback against queued expectations
  initial begin
    exec_exp_t ee;
    done_exp_t de;
    dbg_raddr = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (done) begin
          done_seen++;
          if (dq.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
          end else begin
            de = dq.pop_front();
            dbg_raddr = de.rd;
            #1;
            check("wb_rd", dbg_rdata, de.r);
            check("flag_c", {31'd0, flag_c}, {31'd0, de.c});
            check("flag_z", {31'd0, flag_z}, {31'd0, de.z});
            check("flag_n", {31'd0, flag_n}, {31'd0, de.n});
            check("op_count", {16'd0, op_count}, {16'd0, de.cnt});
            check("done_latency", cyc, de.acc + 1);
            check("opera_hold", alu_opera, de.a);
            check("fun_idle_done", {29'd0, alu_fun}, 32'd0);
          end
        end else if (!instr_ready) begin
          if (eq.size() == 0) begin
            check("unexpected_exec", 32'd1, 32'd0);
          end else begin
            ee = eq.pop_front();
            check("exec_opera", alu_opera, ee.a);
            check("exec_operb", alu_operb, ee.b);
            check("exec_fun", {29'd0, alu_fun}, {29'd0, ee.fun});
            check("exec_cycle", cyc, ee.acc);
          end
        end else begin
          check("fun_idle", {29'd0, alu_fun}, 32'd0);
        end
      end
    end
  end

  initial begin
    int acc, prev, guard, ds0;
    logic [2:0] f, rd, ra, rb;
    rst_n = 1'b0; instr_valid = 1'b0; instr = '0;
    host_we = 1'b0; host_waddr = '0; host_wdata = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'd0, instr_ready}, 32'd1);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_count", {16'd0, op_count}, 32'd0);
    check("rst_opera", alu_opera, 32'd0);
    check("rst_operb", alu_operb, 32'd0);
    check("rst_fun", {29'd0, alu_fun}, 32'd0);
    check("rst_flags", {29'd0, flag_c, flag_z, flag_n}, 32'd0);
    rst_n = 1'b1;

    host_write(3'd1, 32'd5);
    host_write(3'd2, 32'd3);
    issue(FUN_ADD, 3'd3, 3'd1, 3'd2, 0, 0, 3'd0, 32'd0, acc);
    issue(FUN_SUB, 3'd4, 3'd2, 3'd1, 0, 0, 3'd0, 32'd0, acc);
    host_write(3'd5, 32'hFFFF_FFFF);
    host_write(3'd6, 32'd1);
    issue(FUN_ADD, 3'd7, 3'd5, 3'd6, 0, 0, 3'd0, 32'd0, acc);
    issue(FUN_XOR, 3'd0, 3'd1, 3'd1, 0, 0, 3'd0, 32'd0, acc);

    // Back-to-back with instr_valid held high throughout
    prev = -1;
    for (int i = 0; i < 6; i++) begin
      f = 3'($urandom); rd = 3'($urandom); ra = 3'($urandom); rb = 3'($urandom);
      issue(f, rd, ra, rb, 1, 0, 3'd0, 32'd0, acc);
      if (prev >= 0) check("b2b_spacing", acc - prev, 32'd3);
      prev = acc;
    end
    instr_valid = 1'b0;

    host_write(3'd1, 32'h0000_1234);
    host_write(3'd2, 32'h0000_4321);
    issue(FUN_ADD, 3'd3, 3'd1, 3'd2, 0, 1, 3'd3, 32'hDEAD_BEEF, acc);
    issue(FUN_OR,  3'd3, 3'd1, 3'd2, 0, 1, 3'd2, 32'h1234_5678, acc);
    issue(FUN_AND, 3'd4, 3'd2, 3'd3, 0, 0, 3'd0, 32'd0, acc);
    issue(FUN_NOR, 3'd4, 3'd4, 3'd4, 0, 0, 3'd0, 32'd0, acc);
    issue(3'd0,    3'd5, 3'd1, 3'd2, 0, 0, 3'd0, 32'd0, acc);
    issue(3'd7,    3'd6, 3'd1, 3'd2, 0, 0, 3'd0, 32'd0, acc);

    // Reset asserted during EXEC aborts the operation
    host_write(3'd5, 32'h8000_0001);
    @(negedge clk);
    instr = {FUN_ADD, 3'd6, 3'd5, 3'd5, 4'h0};
    instr_valid = 1'b1;
    guard = 0;
    while (!instr_ready && guard < 20) begin @(negedge clk); guard++; end
    @(posedge clk); #2;
    ds0 = done_seen;
    rst_n = 1'b0; instr_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1;
    check("abort_no_done", done_seen, ds0);
    check("abort_ready", {31'd0, instr_ready}, 32'd1);
    check("abort_count", {16'd0, op_count}, 32'd0);
    check("abort_opera", alu_opera, 32'd0);
    check("abort_flags", {29'd0, flag_c, flag_z, flag_n}, 32'd0);
    issue(FUN_OR, 3'd1, 3'd6, 3'd6, 0, 0, 3'd0, 32'd0, acc);

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 2) == 0) host_write(3'($urandom), $urandom);
      f = 3'($urandom); rd = 3'($urandom); ra = 3'($urandom); rb = 3'($urandom);
      if ($urandom_range(0, 3) == 0)
        issue(f, rd, ra, rb, 0, 1, 3'($urandom), $urandom, acc);
      else
        issue(f, rd, ra, rb, 0, 0, 3'd0, 32'd0, acc);
    end

    repeat (4) @(negedge clk);
    check("exec_queue_empty", eq.size(), 32'd0);
    check("done_queue_empty", dq.size(), 32'd0);
    check("final_count", {16'd0, op_count}, {16'd0, mcnt});
    check("final_flags", {29'd0, flag_c, flag_z, flag_n}, {29'd0, mc, mz, mn});
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
